mem_block_arbiter: RTL and testbench
====================================

MEM_BLOCK_ARBITER -- requirements
Module: mem_block_arbiter

Interface
REQ-001 SHALL have parameter req_cnt, default 4: number of block-read requesters sharing one memory port.
REQ-002 SHALL have parameter timeout_cycles, default 256: watchdog limit per transaction, used only under MEM_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-005 SHALL have port en  input  bool_t  global enable; when false, all state holds.
REQ-006 SHALL have port req  input  sys::mem_read_block_req_t [req_cnt]  per-requester request (en, addr), level-held until done.
REQ-007 SHALL have port rsp  output  sys::mem_read_block_rsp_t [req_cnt]  per-requester response (done, data).
REQ-008 SHALL have port mem_req  output  sys::mem_read_block_req_t  request to the shared memory port.
REQ-009 SHALL have port mem_rsp  input  sys::mem_read_block_rsp_t  response from the shared memory port.
REQ-010 SHALL have port grant_id  output  max(1,$clog2(req_cnt))  index of the currently granted requester.
REQ-011 SHALL have port busy  output  bool_t  true while a transaction is outstanding.
REQ-012 SHALL have port timeout_err  output  bool_t  sticky watchdog error flag.

Function
REQ-013 SHALL implement a two-state FSM, ARB_IDLE and ARB_BUSY.
REQ-014 In ARB_IDLE with any req[i].en true, SHALL grant the first requester at or after rr_ptr (wrapping modulo req_cnt), latch its index and addr, and enter ARB_BUSY at the next edge.
REQ-015 mem_req.en and mem_req.addr SHALL be registered; mem_req.en is true exactly while in ARB_BUSY (one cycle after the request is first seen).
REQ-016 After each grant to i, rr_ptr SHALL become (i+1) mod req_cnt; with req_cnt-1 granted it wraps to 0.
REQ-017 In ARB_BUSY, on mem_rsp.done, rsp[grant_id] SHALL carry done=1 and mem_rsp.data combinationally in the same cycle, and the FSM SHALL return to ARB_IDLE at the next edge.
REQ-018 rsp[j] for j not equal to grant_id, and all rsp while in ARB_IDLE, SHALL be done=0, data=0.
REQ-019 If req[grant_id].en drops while in ARB_BUSY, the transaction SHALL complete and its response SHALL be suppressed (done=0).
REQ-020 mem_rsp.done while in ARB_IDLE SHALL be ignored.
REQ-021 The cycle after done, the arbiter SHALL be in ARB_IDLE and re-arbitrate; back-to-back throughput is one transaction per (memory latency + 1) cycles.
REQ-022 Requests arriving while in ARB_BUSY SHALL wait; no request is dropped while its en stays high.
REQ-023 busy SHALL equal (state == ARB_BUSY); grant_id SHALL hold its last value in ARB_IDLE.

Reset
REQ-024 While rst is 0 at a rising edge, the block SHALL enter ARB_IDLE with rr_ptr=0, grant_id=0, watchdog count=0, timeout_err=false, and mem_req=sys::mem_read_block_req_rst.
REQ-025 Reset asserted during ARB_BUSY SHALL abandon the transaction; mem_req.en SHALL be low the cycle after reset, and any later mem_rsp.done SHALL be ignored per REQ-020.
REQ-026 Reset SHALL take priority over en.

Configuration
REQ-027 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL count ARB_BUSY cycles; when it reaches timeout_cycles without done, the block SHALL return to ARB_IDLE, suppress the response, and set timeout_err until reset.
REQ-028 Without MEM_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied false, and ARB_BUSY SHALL wait indefinitely.

Structure
REQ-029 mem_arb_state_t (ARB_IDLE, ARB_BUSY) SHALL live in package sys beside the mem_read_block types.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, rr_ptr; outputs: valid, index).

Verification
REQ-031 Single request: req[2].en with addr 0x1000, memory done after 3 cycles -> mem_req.en one cycle after the request, addr 0x1000, rsp[2].done for exactly 1 cycle, busy low next cycle.
REQ-032 All four requesting continuously from reset -> grants in order 0,1,2,3,0; grant_id matches each mem_req.
REQ-033 Requester 1 drops en mid-transaction -> memory done accepted, rsp[1].done stays 0, next requester granted.
REQ-034 rst=0 during ARB_BUSY, then done arrives -> mem_req.en low, done ignored, rr_ptr=0, all rsp.done 0.
REQ-035 MEM_ARB_TIMEOUT_EN, timeout_cycles=8, memory never responds -> return to ARB_IDLE after 8 busy cycles, timeout_err=1 and held until reset.

Source files
------------

// File: rtl/mem_block_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : sys
// Purpose : Shared types for the block-read memory arbiter: boolean alias,
//           block-read request/response structs, their reset value, the
//           arbiter state enum and a small index-width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sys;

  typedef logic bool_t;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef struct packed {
    bool_t                  en;
    logic [MEM_ADDR_W-1:0]  addr;
  } mem_read_block_req_t;

  typedef struct packed {
    bool_t                  done;
    logic [MEM_DATA_W-1:0]  data;
  } mem_read_block_rsp_t;

  localparam mem_read_block_req_t mem_read_block_req_rst = '{en: 1'b0, addr: '0};

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } mem_arb_state_t;

  // Width of an index able to address n items; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_block_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick: the first asserted request at or
//           after rr_ptr_i, wrapping modulo req_cnt.
// Ports   : req_vec_i  - one request bit per requester
//           rr_ptr_i   - index with highest priority this cycle
//           valid_o    - at least one request is asserted
//           index_o    - chosen requester
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
  import sys::*;
#(
  parameter int req_cnt = 4
) (
  input  logic [req_cnt-1:0]        req_vec_i,
  input  logic [idx_w(req_cnt)-1:0] rr_ptr_i,
  output logic                      valid_o,
  output logic [idx_w(req_cnt)-1:0] index_o
);

  localparam int IW = idx_w(req_cnt);

  logic [IW:0]   cand_sum;
  logic [IW-1:0] cand_idx;

  // Scan offsets from the farthest to the nearest; the last hit wins, so the
  // requester closest to rr_ptr_i is selected without a priority flag.
  always_comb begin
    valid_o  = 1'b0;
    index_o  = '0;
    cand_sum = '0;
    cand_idx = '0;
    for (int k = req_cnt - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr_i} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(req_cnt)) begin
        cand_sum = cand_sum - (IW+1)'(req_cnt);
      end
      cand_idx = cand_sum[IW-1:0];
      if (req_vec_i[cand_idx]) begin
        valid_o = 1'b1;
        index_o = cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_block_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_block_arbiter
// Purpose : Round-robin arbiter sharing one block-read memory port among
//           req_cnt requesters. One transaction outstanding at a time.
// Ports   : clk         - clock, rising edge
//           rst         - synchronous reset, active low
//           en          - global enable; all state holds when low
//           req[]       - per-requester request (en, addr), level-held
//           rsp[]       - per-requester response (done, data)
//           mem_req     - registered request to the shared memory port
//           mem_rsp     - response from the shared memory port
//           grant_id    - index of the current/last granted requester
//           busy        - a transaction is outstanding
//           timeout_err - sticky watchdog error
// Config  : MEM_ARB_TIMEOUT_EN - enables the per-transaction watchdog
//           (timeout_cycles busy cycles without done abort the transaction).
// Revision: 1.0 - initial release
// ============================================================================
module mem_block_arbiter
  import sys::*;
#(
  parameter int req_cnt        = 4,
  parameter int timeout_cycles = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  bool_t                     en,
  input  mem_read_block_req_t       req [req_cnt],
  output mem_read_block_rsp_t       rsp [req_cnt],
  output mem_read_block_req_t       mem_req,
  input  mem_read_block_rsp_t       mem_rsp,
  output logic [idx_w(req_cnt)-1:0] grant_id,
  output bool_t                     busy,
  output bool_t                     timeout_err
);

  localparam int IW = idx_w(req_cnt);

  if (timeout_cycles < 1) begin : g_bad_timeout
    $error("mem_block_arbiter: timeout_cycles must be at least 1");
  end

  mem_arb_state_t      state_q;
  logic [IW-1:0]       grant_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       rr_ptr_d;
  mem_read_block_req_t mem_req_q;

  logic [req_cnt-1:0]  req_vec;
  logic                arb_valid;
  logic [IW-1:0]       arb_idx;
  logic                done_fire;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < req_cnt; i++) begin
      req_vec[i] = req[i].en;
    end
  end

  rr_arbiter #(
    .req_cnt (req_cnt)
  ) u_rr_arbiter (
    .req_vec_i (req_vec),
    .rr_ptr_i  (rr_ptr_q),
    .valid_o   (arb_valid),
    .index_o   (arb_idx)
  );

  assign rr_ptr_d = (arb_idx == IW'(req_cnt - 1)) ? '0 : arb_idx + IW'(1);

  // Memory completion is only consumed when the FSM will actually act on it
  // this edge, so a held or resetting arbiter never reports a response.
  assign done_fire = rst && en && (state_q == ARB_BUSY) && mem_rsp.done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = idx_w(timeout_cycles + 1);
  logic [TW-1:0] wdog_q;
  logic          timeout_err_q;
  logic          wdog_hit;

  // wdog_q is 0 in the first busy cycle, so the match below ends the
  // transaction after exactly timeout_cycles busy cycles.
  assign wdog_hit = (wdog_q == TW'(timeout_cycles - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      mem_req_q <= mem_read_block_req_rst;
`ifdef MEM_ARB_TIMEOUT_EN
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else if (en) begin
      case (state_q)
        ARB_IDLE: begin
          if (arb_valid) begin
            state_q        <= ARB_BUSY;
            grant_q        <= arb_idx;
            rr_ptr_q       <= rr_ptr_d;
            mem_req_q.en   <= 1'b1;
            mem_req_q.addr <= req[arb_idx].addr;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q         <= '0;
`endif
          end
        end
        ARB_BUSY: begin
          if (mem_rsp.done) begin
            state_q      <= ARB_IDLE;
            mem_req_q.en <= 1'b0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wdog_hit) begin
            state_q       <= ARB_IDLE;
            mem_req_q.en  <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + TW'(1);
          end
`endif
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // Route the memory response to the granted requester only, and only while
  // that requester still wants it.
  always_comb begin
    for (int j = 0; j < req_cnt; j++) begin
      rsp[j] = '0;
      if (done_fire && (grant_q == IW'(j)) && req[j].en) begin
        rsp[j].done = 1'b1;
        rsp[j].data = mem_rsp.data;
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == ARB_BUSY);

`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_block_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_block_arbiter
// Purpose : Self-checking bench for mem_block_arbiter (req_cnt = 4). A table
//           of per-cycle vectors covers single request, round robin,
//           requester drop, idle done, enable hold and reset during busy;
//           hand-written sequences cover the watchdog (or its absence).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_block_arbiter;
  import sys::*;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst;
  bool_t               en;
  mem_read_block_req_t req [N];
  mem_read_block_rsp_t rsp [N];
  mem_read_block_req_t mem_req;
  mem_read_block_rsp_t mem_rsp;
  logic [1:0]          grant_id;
  bool_t               busy;
  bool_t               timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] addr_tab [N] = '{32'h0000_0400, 32'h0000_0800, 32'h0000_1000, 32'h0000_2000};

  always #5 clk = ~clk;

  mem_block_arbiter #(
    .req_cnt        (N),
    .timeout_cycles (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .rsp         (rsp),
    .mem_req     (mem_req),
    .mem_rsp     (mem_rsp),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [3:0]  req_en;
    logic        done;
    logic [31:0] data;
    logic        e_busy;
    logic        e_men;
    logic [1:0]  e_gid;
    logic [31:0] e_addr;
    logic [3:0]  e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic [3:0] q,
                              input logic d, input logic [31:0] dat,
                              input logic eb, input logic em, input logic [1:0] eg,
                              input logic [31:0] ea, input logic [3:0] ed);
    vec_t v;
    v.rst_n = r;  v.en = e;      v.req_en = q;  v.done = d;    v.data = dat;
    v.e_busy = eb; v.e_men = em; v.e_gid = eg;  v.e_addr = ea; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [3:0] q);
    for (int i = 0; i < N; i++) begin
      req[i].en   = q[i];
      req[i].addr = addr_tab[i];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] got_done;
    int         nb;
    logic       saw_done;
    vec_t       v;

    //   rst en req     done data          busy men gid addr          rsp.done
    add(1, 1, 4'b0000, 0, 32'h0,          0, 0, 0, 32'h0,        4'b0000);
    add(1, 1, 4'b0100, 0, 32'h0,          0, 0, 0, 32'h0,        4'b0000);
    add(1, 1, 4'b0100, 0, 32'h0,          1, 1, 2, 32'h1000,     4'b0000);
    add(1, 1, 4'b0100, 0, 32'h0,          1, 1, 2, 32'h1000,     4'b0000);
    add(1, 1, 4'b0100, 1, 32'hD000_0001,  1, 1, 2, 32'h1000,     4'b0100);
    add(1, 1, 4'b0000, 0, 32'h0,          0, 0, 2, 32'h1000,     4'b0000);
    add(0, 1, 4'b0000, 0, 32'h0,          0, 0, 2, 32'h1000,     4'b0000);
    // all four requesting from reset: 0,1,2,3,0
    add(1, 1, 4'b1111, 0, 32'h0,          0, 0, 0, 32'h0,        4'b0000);
    add(1, 1, 4'b1111, 0, 32'h0,          1, 1, 0, 32'h0400,     4'b0000);
    add(1, 1, 4'b1111, 1, 32'hD000_0002,  1, 1, 0, 32'h0400,     4'b0001);
    add(1, 1, 4'b1111, 0, 32'h0,          0, 0, 0, 32'h0400,     4'b0000);
    add(1, 1, 4'b1111, 1, 32'hD000_0003,  1, 1, 1, 32'h0800,     4'b0010);
    add(1, 1, 4'b1111, 0, 32'h0,          0, 0, 1, 32'h0800,     4'b0000);
    add(1, 1, 4'b1111, 1, 32'hD000_0004,  1, 1, 2, 32'h1000,     4'b0100);
    add(1, 1, 4'b1111, 0, 32'h0,          0, 0, 2, 32'h1000,     4'b0000);
    add(1, 1, 4'b1111, 1, 32'hD000_0005,  1, 1, 3, 32'h2000,     4'b1000);
    add(1, 1, 4'b1111, 0, 32'h0,          0, 0, 3, 32'h2000,     4'b0000);
    add(1, 1, 4'b1111, 0, 32'h0,          1, 1, 0, 32'h0400,     4'b0000);
    add(1, 1, 4'b1111, 1, 32'hD000_0006,  1, 1, 0, 32'h0400,     4'b0001);
    // requester 1 drops mid-transaction, requester 3 next
    add(1, 1, 4'b1010, 0, 32'h0,          0, 0, 0, 32'h0400,     4'b0000);
    add(1, 1, 4'b1010, 0, 32'h0,          1, 1, 1, 32'h0800,     4'b0000);
    add(1, 1, 4'b1000, 1, 32'hD000_0007,  1, 1, 1, 32'h0800,     4'b0000);
    add(1, 1, 4'b1000, 0, 32'h0,          0, 0, 1, 32'h0800,     4'b0000);
    add(1, 1, 4'b1000, 0, 32'h0,          1, 1, 3, 32'h2000,     4'b0000);
    add(1, 1, 4'b1000, 1, 32'hD000_0008,  1, 1, 3, 32'h2000,     4'b1000);
    // done while idle is ignored
    add(1, 1, 4'b0000, 1, 32'hD000_0009,  0, 0, 3, 32'h2000,     4'b0000);
    add(1, 1, 4'b0000, 0, 32'h0,          0, 0, 3, 32'h2000,     4'b0000);
    // global enable low holds state
    add(1, 0, 4'b0001, 0, 32'h0,          0, 0, 3, 32'h2000,     4'b0000);
    add(1, 0, 4'b0001, 0, 32'h0,          0, 0, 3, 32'h2000,     4'b0000);
    add(1, 1, 4'b0001, 0, 32'h0,          0, 0, 3, 32'h2000,     4'b0000);
    add(1, 1, 4'b0001, 0, 32'h0,          1, 1, 0, 32'h0400,     4'b0000);
    add(1, 0, 4'b0001, 0, 32'h0,          1, 1, 0, 32'h0400,     4'b0000);
    add(1, 1, 4'b0001, 1, 32'hD000_000A,  1, 1, 0, 32'h0400,     4'b0001);
    // reset during busy, then a stale done
    add(1, 1, 4'b0100, 0, 32'h0,          0, 0, 0, 32'h0400,     4'b0000);
    add(1, 1, 4'b0100, 0, 32'h0,          1, 1, 2, 32'h1000,     4'b0000);
    add(0, 1, 4'b0100, 0, 32'h0,          1, 1, 2, 32'h1000,     4'b0000);
    add(1, 1, 4'b0000, 1, 32'hD000_000B,  0, 0, 0, 32'h0,        4'b0000);
    add(1, 1, 4'b1111, 0, 32'h0,          0, 0, 0, 32'h0,        4'b0000);
    add(1, 1, 4'b1111, 0, 32'h0,          1, 1, 0, 32'h0400,     4'b0000);
    add(1, 1, 4'b1111, 1, 32'hD000_000C,  1, 1, 0, 32'h0400,     4'b0001);
    add(1, 1, 4'b0000, 0, 32'h0,          0, 0, 0, 32'h0400,     4'b0000);

    // ---------------- reset state ----------------
    rst = 1'b0;
    en  = 1'b1;
    drive_req(4'b0000);
    mem_rsp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset busy",        64'(busy),        64'd0);
    check("reset mem_req.en",  64'(mem_req.en),  64'd0);
    check("reset mem_req.addr",64'(mem_req.addr),64'd0);
    check("reset grant_id",    64'(grant_id),    64'd0);
    check("reset timeout_err", 64'(timeout_err), 64'd0);
    for (int j = 0; j < N; j++) got_done[j] = rsp[j].done;
    check("reset rsp.done",    64'(got_done),    64'd0);

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      rst = v.rst_n;
      en  = v.en;
      drive_req(v.req_en);
      mem_rsp.done = v.done;
      mem_rsp.data = v.data;
      #1;
      for (int j = 0; j < N; j++) got_done[j] = rsp[j].done;
      check($sformatf("row%0d busy", i),        64'(busy),         64'(v.e_busy));
      check($sformatf("row%0d mem_req.en", i),  64'(mem_req.en),   64'(v.e_men));
      check($sformatf("row%0d grant_id", i),    64'(grant_id),     64'(v.e_gid));
      check($sformatf("row%0d mem_req.addr", i),64'(mem_req.addr), 64'(v.e_addr));
      check($sformatf("row%0d rsp.done", i),    64'(got_done),     64'(v.e_done));
      for (int j = 0; j < N; j++) begin
        check($sformatf("row%0d rsp[%0d].data", i, j), 64'(rsp[j].data),
              v.e_done[j] ? 64'(v.data) : 64'd0);
      end
      check($sformatf("row%0d timeout_err", i), 64'(timeout_err),  64'd0);
    end

    // ---------------- watchdog ----------------
    // rr_ptr is 1 here, so requester 1 is granted.
    @(negedge clk);
    drive_req(4'b0010);
    mem_rsp = '0;
    nb = 0;
    saw_done = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (rsp[1].done) saw_done = 1'b1;
      if (busy) nb++;
      else if (nb > 0) break;
    end
    drive_req(4'b0000);
    check("timeout busy cycles",   64'(nb),          64'd8);
    check("timeout rsp suppressed",64'(saw_done),    64'd0);
    check("timeout err set",       64'(timeout_err), 64'd1);
    check("timeout mem_req.en",    64'(mem_req.en),  64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("timeout err sticky",    64'(timeout_err), 64'd1);
    check("timeout idle",          64'(busy),        64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("timeout err cleared",   64'(timeout_err), 64'd0);
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (rsp[1].done) saw_done = 1'b1;
      if (busy) nb++;
    end
    check("no-watchdog busy cycles", 64'(nb),          64'd20);
    check("no-watchdog no rsp",      64'(saw_done),    64'd0);
    check("no-watchdog err",         64'(timeout_err), 64'd0);
    mem_rsp.done = 1'b1;
    mem_rsp.data = 32'hBEEF_0001;
    #1;
    check("no-watchdog late done",   64'(rsp[1].done), 64'd1);
    check("no-watchdog late data",   64'(rsp[1].data), 64'h0000_0000_BEEF_0001);
    @(negedge clk);
    drive_req(4'b0000);
    mem_rsp = '0;
    #1;
    check("no-watchdog idle after",  64'(busy),        64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
